uart_tx_sched: RTL

Scheduler that shares one UART transmitter and its baud generator between NREQ byte requesters. It arbitrates round-robin and latches the winner's byte and baud selection. Baud changes are applied only while the transmitter is idle: the baud generator is restarted and a settle time is enforced. The block then issues a one-cycle start to the transmitter and tracks its busy flag until the frame completes. It sits between the client logic and the UART transmitter/baud generator pair, on the 50 MHz system clock.

---
 rtl/uart_tx_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter and its baud generator among
// NREQ byte requesters. Round-robin capture in IDLE, optional baud
// reconfiguration with a settle delay, a one-cycle tx_start, then tracking
// of tx_busy until the frame completes.
// Optional feature macro: UART_SCHED_TIMEOUT_EN adds a watchdog on the
// WAIT_BUSY/WAIT_DONE states that pulses err and abandons the frame.
module uart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_baud,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        tx_baud,
  output logic              baud_rst_n,
  output logic [2:0]        cur_id,
  output logic              sched_busy,
  output logic              err
);

  localparam int IW = (NREQ <= 2) ? 1 : $clog2(NREQ);
  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]   SETTLE_LIM = SW'(SETTLE_CYC);
  localparam logic [NREQ-1:0] ACK_ONE    = NREQ'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG       = 3'd1,
    SETTLE    = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   cur_idx_r;
  logic [1:0]      baud_lat_r;
  logic [SW-1:0]   settle_cnt_r;
  logic [NREQ-1:0] req_ack_r;
  logic [7:0]      tx_data_r;
  logic            tx_start_r;
  logic [1:0]      tx_baud_r;
  logic            baud_rst_n_r;
  logic            sched_busy_r;

  logic            grant_found_s;
  logic [IW-1:0]   grant_id_s;
  logic [7:0]      grant_data_s;
  logic [1:0]      grant_baud_s;
  logic            tout_hit_s;

  // Index base+off wrapped modulo NREQ (off never exceeds NREQ-1).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return sum[IW-1:0];
  endfunction

  // Round-robin winner: first set request searching upward from rr_ptr_r.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found_s && req_valid[wrap_add(rr_ptr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_id_s    = wrap_add(rr_ptr_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign grant_data_s = req_data[{grant_id_s, 3'b000} +: 8];
  assign grant_baud_s = req_baud[{grant_id_s, 1'b0} +: 2];

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TOUT_LIM = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tout_cnt_r;
  logic          err_r;

  // Watchdog: restarts on entry to WAIT_BUSY or WAIT_DONE, counts while in them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tout_cnt_r <= '0;
    end else if ((state_r == START) || ((state_r == WAIT_BUSY) && tx_busy)) begin
      tout_cnt_r <= '0;
    end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) begin
      tout_cnt_r <= tout_cnt_r + TW'(1);
    end else begin
      tout_cnt_r <= '0;
    end
  end

  assign tout_hit_s = (tout_cnt_r == TOUT_LIM);
  assign err        = err_r;
`else
  assign tout_hit_s = 1'b0;
  assign err        = 1'b0;
`endif

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      cur_idx_r    <= '0;
      baud_lat_r   <= 2'b00;
      settle_cnt_r <= '0;
      req_ack_r    <= '0;
      tx_data_r    <= 8'h00;
      tx_start_r   <= 1'b0;
      tx_baud_r    <= 2'b00;
      baud_rst_n_r <= 1'b1;
      sched_busy_r <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      err_r        <= 1'b0;
`endif
    end else begin
      req_ack_r    <= '0;
      tx_start_r   <= 1'b0;
      baud_rst_n_r <= 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
      err_r        <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            cur_idx_r    <= grant_id_s;
            tx_data_r    <= grant_data_s;
            baud_lat_r   <= grant_baud_s;
            req_ack_r    <= ACK_ONE << grant_id_s;
            sched_busy_r <= 1'b1;
            state_r      <= (grant_baud_s == tx_baud_r) ? START : CFG;
          end else begin
            sched_busy_r <= 1'b0;
          end
        end
        CFG: begin
          // New baud goes out together with a one-cycle generator restart.
          tx_baud_r    <= baud_lat_r;
          baud_rst_n_r <= 1'b0;
          settle_cnt_r <= '0;
          state_r      <= (SETTLE_CYC == 0) ? START : SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LIM) begin
            state_r <= START;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        START: begin
          tx_start_r <= 1'b1;
          state_r    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_r <= WAIT_DONE;
          end else if (tout_hit_s) begin
            baud_rst_n_r <= 1'b0;
            sched_busy_r <= 1'b0;
            rr_ptr_r     <= wrap_add(cur_idx_r, 1);
            state_r      <= IDLE;
`ifdef UART_SCHED_TIMEOUT_EN
            err_r        <= 1'b1;
`endif
          end else begin
            state_r <= WAIT_BUSY;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy || tout_hit_s) begin
            sched_busy_r <= 1'b0;
            rr_ptr_r     <= wrap_add(cur_idx_r, 1);
            state_r      <= IDLE;
            if (tx_busy) begin
              // Only reachable on watchdog expiry with the transmitter stuck busy.
              baud_rst_n_r <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
              err_r        <= 1'b1;
`endif
            end else begin
              baud_rst_n_r <= 1'b1;
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          sched_busy_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req_ack    = req_ack_r;
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign tx_baud    = tx_baud_r;
  assign baud_rst_n = baud_rst_n_r;
  assign cur_id     = 3'(cur_idx_r);
  assign sched_busy = sched_busy_r;

endmodule
